// File: rtl/reg_rename_table_if.sv
// reg_rename_table_if: rename-table bus between decode/commit (master) and the alias table (slave).
// Ports: src_arch/src_phys (source lookup), rename_en/rename_arch/rename_ready/rename_phys/rename_old_phys
// (destination rename), commit_en/commit_arch/commit_phys/commit_old_phys (in-order commit), flush,
// free_count (speculative free-list occupancy).
interface reg_rename_table_if #(
    parameter int ARCH_ADDR_WIDTH = 6,
    parameter int PHYS_ADDR_WIDTH = 7,
    parameter int READ_PORTS      = 2
);
    logic [READ_PORTS*ARCH_ADDR_WIDTH-1:0] src_arch;
    logic [READ_PORTS*PHYS_ADDR_WIDTH-1:0] src_phys;
    logic                                  rename_en;
    logic [ARCH_ADDR_WIDTH-1:0]            rename_arch;
    logic                                  rename_ready;
    logic [PHYS_ADDR_WIDTH-1:0]            rename_phys;
    logic [PHYS_ADDR_WIDTH-1:0]            rename_old_phys;
    logic                                  commit_en;
    logic [ARCH_ADDR_WIDTH-1:0]            commit_arch;
    logic [PHYS_ADDR_WIDTH-1:0]            commit_phys;
    logic [PHYS_ADDR_WIDTH-1:0]            commit_old_phys;
    logic                                  flush;
    logic [PHYS_ADDR_WIDTH:0]              free_count;

    modport master (
        output src_arch, rename_en, rename_arch, commit_en, commit_arch, commit_phys,
               commit_old_phys, flush,
        input  src_phys, rename_ready, rename_phys, rename_old_phys, free_count
    );

    modport slave (
        input  src_arch, rename_en, rename_arch, commit_en, commit_arch, commit_phys,
               commit_old_phys, flush,
        output src_phys, rename_ready, rename_phys, rename_old_phys, free_count
    );
endinterface

// File: rtl/reg_rename_table.sv
// reg_rename_table: register alias table with speculative/committed maps and a circular free list.
// Ports: clk (rising-edge clock), rst (asynchronous active-low reset),
// bus (reg_rename_table_if.slave: source lookup, rename, commit, flush, free_count).
module reg_rename_table #(
    parameter int ARCH_REGS       = 64,
    parameter int ARCH_ADDR_WIDTH = 6,
    parameter int PHYS_REGS       = 128,
    parameter int PHYS_ADDR_WIDTH = 7,
    parameter int READ_PORTS      = 2
) (
    input logic              clk,
    input logic              rst,
    reg_rename_table_if.slave bus
);
    localparam int AW = ARCH_ADDR_WIDTH;
    localparam int PW = PHYS_ADDR_WIDTH;

    logic [PW-1:0] spec_map   [ARCH_REGS];
    logic [PW-1:0] commit_map [ARCH_REGS];
    logic [PW-1:0] free_fifo  [PHYS_REGS];
    logic [PW:0]   spec_head, commit_head, tail;
    logic [PW:0]   free_count;
    logic [PW-1:0] head_tag;
    logic          rename_ready, arch_zero, do_rename, do_commit;

    always_comb begin
        free_count   = tail - spec_head;
        rename_ready = free_count != '0;
        head_tag     = free_fifo[spec_head[PW-1:0]];
        arch_zero    = bus.rename_arch == '0;
        // flush wins over a same-cycle rename; address 0 never consumes a tag
        do_rename    = bus.rename_en && rename_ready && !arch_zero && !bus.flush;
        do_commit    = bus.commit_en && bus.commit_arch != '0;
    end

    assign bus.free_count      = free_count;
    assign bus.rename_ready    = rename_ready;
    assign bus.rename_phys     = arch_zero ? '0 : head_tag;
    assign bus.rename_old_phys = arch_zero ? '0 : spec_map[bus.rename_arch];

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_src
        assign bus.src_phys[g*PW +: PW] = spec_map[bus.src_arch[g*AW +: AW]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i]   <= PW'(i);
                commit_map[i] <= PW'(i);
            end
            // entries beyond the initial free tags are don't-care until a commit writes them
            for (int j = 0; j < PHYS_REGS; j++) free_fifo[j] <= PW'(ARCH_REGS + j);
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= (PW+1)'(PHYS_REGS - ARCH_REGS);
        end else begin
            if (do_commit) begin
                commit_map[bus.commit_arch] <= bus.commit_phys;
                free_fifo[tail[PW-1:0]]     <= bus.commit_old_phys;
                tail                        <= tail + (PW+1)'(1);
                commit_head                 <= commit_head + (PW+1)'(1);
            end
            if (bus.flush) begin
                // restore from the committed map with this cycle's commit folded in
                for (int i = 0; i < ARCH_REGS; i++)
                    spec_map[i] <= (do_commit && bus.commit_arch == AW'(i)) ? bus.commit_phys
                                                                             : commit_map[i];
                spec_head <= commit_head + (PW+1)'(do_commit);
            end else if (do_rename) begin
                spec_map[bus.rename_arch] <= head_tag;
                spec_head                 <= spec_head + (PW+1)'(1);
            end
        end
    end
endmodule
